control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 50 +++++
 rtl/alu_decoder.sv | 47 ++++
 rtl/control_unit.sv | 118 +++++++++++
 tb/tb_control_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// control_unit_pkg
//   Shared constants for the single-cycle control unit: supported opcodes,
//   ALUControl encodings, branch funct3 codes and immediate-format selects,
//   plus the decoded control-word type used between the decoder stages.
package control_unit_pkg;

    // Supported major opcodes (instruction bits [6:0])
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] ITYPE  = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SHL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHR = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    // Branch condition codes (funct3)
    localparam logic [2:0] BEQ = 3'b000;
    localparam logic [2:0] BNE = 3'b001;
    localparam logic [2:0] BLT = 3'b100;
    localparam logic [2:0] BGE = 3'b101;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // Main-decoder output bundle; is_branch gates the branch-condition logic.
    typedef struct packed {
        logic       is_branch;
        logic       result_src;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] imm_src;
    } ctrl_t;

    // True for the five opcodes this unit decodes.
    function automatic logic is_supported(input logic [6:0] op);
        return (op == LOAD) || (op == STORE) || (op == RTYPE) ||
               (op == ITYPE) || (op == BRANCH);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
//   Derives ALUControl from opcode/funct3/funct7.
//   Ports:
//     opcode      in  7  instruction bits [6:0]
//     funct3      in  3  instruction bits [14:12]
//     funct7      in  1  instruction bit 30 (selects sub for R-type funct3 000)
//     alu_control out 3  ALU operation encoding
module alu_decoder
    import control_unit_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7,
    output logic [2:0] alu_control
);

    logic [2:0] op_by_funct3;
    logic       is_rtype;

    assign is_rtype = (opcode == RTYPE);

    // Arithmetic/logic mapping shared by R-type and I-type. Only R-type may
    // turn funct3 000 into a subtract; I-type has no funct7 field there.
    always_comb begin
        op_by_funct3 = ALU_ADD;
        case (funct3)
            3'b000:  op_by_funct3 = (is_rtype && funct7) ? ALU_SUB : ALU_ADD;
            3'b001:  op_by_funct3 = ALU_SHL;
            3'b100:  op_by_funct3 = ALU_XOR;
            3'b101:  op_by_funct3 = ALU_SHR;  // arithmetic/logical share one code
            3'b110:  op_by_funct3 = ALU_OR;
            3'b111:  op_by_funct3 = ALU_AND;
            default: op_by_funct3 = ALU_ADD;  // slt/sltu not supported
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (opcode)
            LOAD, STORE:  alu_control = ALU_ADD;  // address generation
            RTYPE, ITYPE: alu_control = op_by_funct3;
            BRANCH:       alu_control = ALU_SUB;  // compare via subtraction
            default:      alu_control = ALU_ADD;  // all-zero for unsupported ops
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit
//   Single-cycle instruction decoder. All control outputs except IllegalOp
//   are combinational from the current inputs and ignore rst.
//   Ports:
//     clk        in  1  rising-edge clock, only clocks IllegalOp
//     rst        in  1  asynchronous active-high reset of IllegalOp
//     opcode     in  7  instruction bits [6:0]
//     funct3     in  3  instruction bits [14:12]
//     funct7     in  1  instruction bit 30
//     zeroFlag   in  1  ALU result == 0
//     signFlag   in  1  ALU result sign
//     PCSrc      out 1  take branch target
//     ResultSrc  out 1  writeback from data memory
//     MemWrite   out 1  data-memory write enable
//     ALUSrc     out 1  ALU operand B is the immediate
//     RegWrite   out 1  register-file write enable
//     ImmSrc     out 2  immediate format (00 I, 01 S, 10 B)
//     ALUControl out 3  ALU operation
//     IllegalOp  out 1  sticky: an unsupported opcode was seen at a clock edge
module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zeroFlag,
    input  logic       signFlag,
    output logic       PCSrc,
    output logic       ResultSrc,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalOp
);

    ctrl_t      ctrl;
    logic [2:0] alu_control;
    logic       branch_taken;
    logic       illegal_d;
    logic       illegal_q;

    alu_decoder u_alu_decoder (
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (alu_control)
    );

    // Main decoder
    always_comb begin
        ctrl = '0;
        case (opcode)
            LOAD: begin
                ctrl.result_src = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.imm_src    = IMM_I;
            end
            STORE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_S;
            end
            RTYPE: begin
                ctrl.reg_write  = 1'b1;
                ctrl.imm_src    = IMM_I;
            end
            ITYPE: begin
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.imm_src    = IMM_I;
            end
            BRANCH: begin
                ctrl.is_branch  = 1'b1;
                ctrl.imm_src    = IMM_B;
            end
            default: ctrl = '0;
        endcase
    end

    // Branch condition; only meaningful when the main decoder flags a branch.
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            BEQ:     branch_taken = zeroFlag;
            BNE:     branch_taken = ~zeroFlag;
            BLT:     branch_taken = signFlag;
            BGE:     branch_taken = ~signFlag;
            default: branch_taken = 1'b0;
        endcase
    end

    assign PCSrc      = ctrl.is_branch & branch_taken;
    assign ResultSrc  = ctrl.result_src;
    assign MemWrite   = ctrl.mem_write;
    assign ALUSrc     = ctrl.alu_src;
    assign RegWrite   = ctrl.reg_write;
    assign ImmSrc     = ctrl.imm_src;
    assign ALUControl = alu_control;

    // Sticky illegal-opcode flag; only rst clears it.
    assign illegal_d = illegal_q | ~is_supported(opcode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a driver applies stimulus shortly after
// each rising edge and queues the reference-model prediction; a monitor pops
// and compares on the following falling edge.
module tb_control_unit;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = OP_RTYPE;
    logic [2:0] funct3 = 3'b000;
    logic       funct7 = 1'b0;
    logic       zeroFlag = 1'b0;
    logic       signFlag = 1'b0;
    logic       PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite, IllegalOp;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;

    control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .zeroFlag   (zeroFlag),
        .signFlag   (signFlag),
        .PCSrc      (PCSrc),
        .ResultSrc  (ResultSrc),
        .MemWrite   (MemWrite),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .IllegalOp  (IllegalOp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] op;
        logic [9:0] ctrl;     // {PCSrc,ResultSrc,MemWrite,ALUSrc,RegWrite,ImmSrc,ALUControl}
        logic       illegal;
    } exp_t;

    exp_t exp_q[$];
    event async_ev;
    logic stim_done = 1'b0;
    logic sticky = 1'b0;      // model of IllegalOp
    int   checks = 0;
    int   errors = 0;

    function automatic logic legal(input logic [6:0] op);
        return op == OP_LOAD || op == OP_STORE || op == OP_RTYPE ||
               op == OP_ITYPE || op == OP_BRANCH;
    endfunction

    // ALU code equals funct3, except 010/011 fall back to add.
    function automatic logic [2:0] alu_of(input logic [2:0] f3);
        return (f3 == 3'd2 || f3 == 3'd3) ? 3'd0 : f3;
    endfunction

    function automatic logic [9:0] ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                              input logic f7, input logic z, input logic s);
        logic pc, rs, mw, as, rw;
        logic [1:0] imm;
        logic [2:0] alu;
        {pc, rs, mw, as, rw, imm, alu} = '0;
        if (op == OP_LOAD) begin
            rs = 1; as = 1; rw = 1;
        end else if (op == OP_STORE) begin
            mw = 1; as = 1; imm = 2'b01;
        end else if (op == OP_RTYPE) begin
            rw = 1;
            alu = (f3 == 3'd0 && f7) ? 3'b010 : alu_of(f3);
        end else if (op == OP_ITYPE) begin
            as = 1; rw = 1;
            alu = alu_of(f3);
        end else if (op == OP_BRANCH) begin
            imm = 2'b10; alu = 3'b010;
            if (f3 == 3'd0)      pc = z;
            else if (f3 == 3'd1) pc = !z;
            else if (f3 == 3'd4) pc = s;
            else if (f3 == 3'd5) pc = !s;
        end
        return {pc, rs, mw, as, rw, imm, alu};
    endfunction

    // Model of what happens to IllegalOp at a rising edge, using the inputs held there.
    task automatic edge_update();
        if (rst) sticky = 1'b0;
        else if (!legal(opcode)) sticky = 1'b1;
    endtask

    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic z, input logic s, input logic r);
        exp_t e;
        @(posedge clk);
        edge_update();
        #1;
        opcode = op; funct3 = f3; funct7 = f7; zeroFlag = z; signFlag = s; rst = r;
        if (r) sticky = 1'b0;
        e.op = op;
        e.ctrl = ref_decode(op, f3, f7, z, s);
        e.illegal = sticky;
        exp_q.push_back(e);
    endtask

    // Reset pulse entirely between two rising edges.
    task automatic async_pulse();
        @(posedge clk);
        edge_update();
        #1 rst = 1'b1;
        sticky = 1'b0;
        #1 -> async_ev;
        #1 rst = 1'b0;
    endtask

    // Driver
    initial begin
        logic [6:0] op_list [5];
        logic [6:0] op;
        op_list[0] = OP_LOAD;  op_list[1] = OP_STORE; op_list[2] = OP_RTYPE;
        op_list[3] = OP_ITYPE; op_list[4] = OP_BRANCH;
        #1 rst = 1'b1;

        // Reset phase: decode stays live, illegal opcode ignored while rst high,
        // then sets on the first edge after release.
        step(OP_RTYPE, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(OP_BAD,   3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(OP_BAD,   3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(OP_BAD,   3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(OP_RTYPE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(OP_LOAD,  3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(OP_LOAD,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed decode
        step(OP_STORE, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int f = 0; f < 8; f++) begin
            step(OP_RTYPE, 3'(f), 1'b0, 1'b0, 1'b0, 1'b0);
            step(OP_RTYPE, 3'(f), 1'b1, 1'b1, 1'b1, 1'b0);
        end
        step(OP_BRANCH, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(OP_BRANCH, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(OP_BRANCH, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(OP_BRANCH, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        step(OP_BRANCH, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        step(OP_BRANCH, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        step(OP_ITYPE,  3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(OP_ITYPE,  3'd5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Illegal-opcode sequence with an asynchronous clear
        step(OP_BAD,   3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(OP_RTYPE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(OP_RTYPE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        async_pulse();
        step(OP_RTYPE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 9) op = 7'($urandom);
            else op = op_list[$urandom_range(0, 4)];
            step(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) async_pulse();
        end

        @(posedge clk);
        stim_done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        fork
            begin
                int cycles = 0;
                forever begin
                    @(negedge clk);
                    cycles++;
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        logic [9:0] act;
                        e = exp_q.pop_front();
                        act = {PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite, ImmSrc, ALUControl};
                        checks++;
                        if (act !== e.ctrl) begin
                            errors++;
                            $display("FAIL decode op=%b f3=%b f7=%b z=%b s=%b rst=%b: got %b expected %b",
                                     e.op, funct3, funct7, zeroFlag, signFlag, rst, act, e.ctrl);
                        end
                        checks++;
                        if (IllegalOp !== e.illegal) begin
                            errors++;
                            $display("FAIL illegal_op at t=%0t op=%b: got %b expected %b",
                                     $time, e.op, IllegalOp, e.illegal);
                        end
                    end else if (stim_done) begin
                        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                        $finish;
                    end
                    if (cycles > 20000) begin
                        errors++;
                        $display("FAIL timeout: got %0d cycles expected completion", cycles);
                        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                        $finish;
                    end
                end
            end
            begin
                forever begin
                    @(async_ev);
                    checks++;
                    if (IllegalOp !== 1'b0) begin
                        errors++;
                        $display("FAIL async_clear at t=%0t: got %b expected 0", $time, IllegalOp);
                    end
                end
            end
        join
    end

endmodule
